// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time pattern analysis for the serial
// sequence detector: failure (border) function and next-depth function.
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam bit         DEF_OVERLAP = 1'b1;
  localparam int         DEF_CNT_W   = 8;
  localparam int         MAX_PAT_W   = 16;

  typedef logic [MAX_PAT_W-1:0] pat_t;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input pat_t pat, input int w, input int i);
    pat_t s;
    s = pat >> (w - 1 - i);
    return s[0];
  endfunction

  // Longest proper border of the first q pattern bits.
  function automatic int fail_len(input pat_t pat, input int w, input int q);
    logic ok;
    for (int k = q - 1; k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (pat_bit(pat, w, q - k + j) != pat_bit(pat, w, j)) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  // Depth reached from depth d on bit b: the longest pattern prefix that is a
  // suffix of (prefix_d, b). A result of w means the pattern just completed.
  function automatic int next_depth(input pat_t pat, input int w, input int d, input logic b);
    logic ok;
    logic sb;
    int   idx;
    for (int k = d + 1; k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        idx = d + 1 - k + j;
        sb  = (idx == d) ? b : pat_bit(pat, w, idx);
        if (sb != pat_bit(pat, w, j)) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // its inputs from the same pre-edge values; blocking here would race.
  always_ff @(posedge clock) begin
    if (reset || clr)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/seq_detector.sv
// KMP-style serial pattern detector: depth register driven by constant
// transition tables built from PATTERN, plus a saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter bit             OVERLAP = DEF_OVERLAP,
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic             clear_cnt,
  output logic             y_out,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W  = $clog2(PAT_W);
  localparam int BORDER = fail_len(pat_t'(PATTERN), PAT_W, PAT_W);
  localparam int RESTART = OVERLAP ? BORDER : 0;

  logic [IDX_W-1:0] depth, depth_nxt;
  logic             hit;

  // Constant tables indexed by [depth][bit]; a completed pattern maps straight
  // to the post-match restart depth so depth never needs to hold PAT_W.
  logic [IDX_W-1:0] dep_tbl [PAT_W][2];
  logic             hit_tbl [PAT_W][2];

  for (genvar d = 0; d < PAT_W; d++) begin : g_depth
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NXT = next_depth(pat_t'(PATTERN), PAT_W, d, 1'(b));
      assign hit_tbl[d][b] = (NXT == PAT_W);
      assign dep_tbl[d][b] = (NXT == PAT_W) ? IDX_W'(RESTART) : IDX_W'(NXT);
    end
  end

  // NOTE: defaults first so every path assigns every output; no latch inferred.
  always_comb begin
    depth_nxt = depth;
    hit       = 1'b0;
    if (x_valid) begin
      depth_nxt = dep_tbl[depth][x_in];
      hit       = hit_tbl[depth][x_in];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth <= '0;
      y_out <= 1'b0;
      busy  <= 1'b0;
    end else begin
      depth <= depth_nxt;
      y_out <= hit;
      busy  <= (depth_nxt != '0);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (clear_cnt),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench: four detector configurations share one stimulus stream;
// a history-based model feeds a scoreboard, plus hand tables and sequences.
module tb_seq_detector;

  logic clock = 1'b0;
  logic reset, x_in, x_valid, clear_cnt;

  logic       y_ov, y_no, y_sat, y_six;
  logic       b_ov, b_no, b_sat, b_six;
  logic [7:0] c_ov, c_no, c_six;
  logic [1:0] c_sat;

  always #5 clock = ~clock;

  seq_detector u_ov (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear_cnt(clear_cnt),
    .y_out(y_ov), .busy(b_ov), .match_cnt(c_ov));
  seq_detector #(.OVERLAP(1'b0)) u_no (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear_cnt(clear_cnt),
    .y_out(y_no), .busy(b_no), .match_cnt(c_no));
  seq_detector #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear_cnt(clear_cnt),
    .y_out(y_sat), .busy(b_sat), .match_cnt(c_sat));
  seq_detector #(.PAT_W(6), .PATTERN(6'b101101)) u_six (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear_cnt(clear_cnt),
    .y_out(y_six), .busy(b_six), .match_cnt(c_six));

  logic [3:0] ys, bs;
  logic [7:0] cs [4];
  assign ys = {y_six, y_sat, y_no, y_ov};
  assign bs = {b_six, b_sat, b_no, b_ov};
  assign cs[0] = c_ov;
  assign cs[1] = c_no;
  assign cs[2] = {6'b0, c_sat};
  assign cs[3] = c_six;

  // Model configuration per instance: 0 ov, 1 non-overlap, 2 CNT_W=2, 3 six-bit.
  int          pw   [4] = '{4, 4, 4, 6};
  logic [31:0] pat  [4] = '{32'b1011, 32'b1011, 32'b1011, 32'b101101};
  bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax [4] = '{255, 255, 3, 255};

  logic [31:0] hist [4];
  int          len  [4];
  int          mc   [4];

  typedef struct packed {
    logic [3:0]      y;
    logic [3:0]      busy;
    logic [3:0][7:0] cnt;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic rst, v, b, clr;
    logic ey, eb;
    int   ec;
  } vec_t;
  vec_t tbl [$];

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d, expected %0d at %0t", phase, name, act, exp, $time);
    end
  endtask

  // Longest pattern prefix (shorter than the pattern) ending the seen history.
  function automatic int model_depth(input int i);
    for (int k = pw[i] - 1; k > 0; k--)
      if (k <= len[i] && ((hist[i] & ((32'd1 << k) - 32'd1)) == (pat[i] >> (pw[i] - k))))
        return k;
    return 0;
  endfunction

  // Drive one cycle, push model expectations, compare after the edge.
  task automatic step(input logic rst, input logic v, input logic b, input logic clr);
    exp_t e;
    logic m;
    @(negedge clock);
    reset = rst; x_valid = v; x_in = b; clear_cnt = clr;
    for (int i = 0; i < 4; i++) begin
      m = 1'b0;
      if (rst) begin
        hist[i] = '0; len[i] = 0; mc[i] = 0;
      end else begin
        if (v) begin
          hist[i] = {hist[i][30:0], b};
          if (len[i] < 32) len[i]++;
          m = (len[i] >= pw[i]) && ((hist[i] & ((32'd1 << pw[i]) - 32'd1)) == pat[i]);
          if (m && !ov[i]) len[i] = 0;
        end
        if (clr) mc[i] = 0;
        else if (m && mc[i] < cmax[i]) mc[i]++;
      end
      e.y[i]    = m;
      e.busy[i] = rst ? 1'b0 : (model_depth(i) != 0);
      e.cnt[i]  = 8'(mc[i]);
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("y%0d", i),    ys[i], e.y[i]);
      check($sformatf("busy%0d", i), bs[i], e.busy[i]);
      check($sformatf("cnt%0d", i),  cs[i], e.cnt[i]);
    end
  endtask

  task automatic add(input logic rst, v, b, clr, ey, eb, input int ec);
    vec_t t;
    t.rst = rst; t.v = v; t.b = b; t.clr = clr; t.ey = ey; t.eb = eb; t.ec = ec;
    tbl.push_back(t);
  endtask

  // Feed n valid bits (bits[n-1] first) and check the given instance's pulses.
  task automatic run_bits(input logic [31:0] bits, input int n, input logic [31:0] pulse,
                          input int inst);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, bits[n-1-i], 1'b0);
      check($sformatf("seq_y%0d_bit%0d", inst, i + 1), ys[inst], pulse[n-1-i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; x_in = 1'b0; x_valid = 1'b0; clear_cnt = 1'b0;

    // Hand-derived vectors for the default overlapping 1011 detector.
    add(1,0,0,0, 0,0,0);
    add(0,1,1,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,1,0, 0,1,0);
    add(0,1,1,0, 1,1,1); add(0,1,0,0, 0,1,1); add(0,1,1,0, 0,1,1);
    add(0,1,1,0, 1,1,2);
    add(0,1,0,1, 0,1,0);                                   // clear without match
    add(1,0,0,0, 0,0,0);
    add(0,1,1,0, 0,1,0); add(0,1,0,0, 0,1,0);
    add(0,0,1,0, 0,1,0); add(0,0,1,0, 0,1,0); add(0,0,0,0, 0,1,0);   // gap
    add(0,1,1,0, 0,1,0); add(0,1,1,0, 1,1,1);
    add(1,0,0,0, 0,0,0);
    add(0,1,1,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,1,0, 0,1,0);
    add(1,1,1,1, 0,0,0);                                   // reset wins over valid/clear
    add(0,1,1,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,1,0, 0,1,0);
    add(0,1,1,0, 1,1,1);

    phase = "table";
    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].v, tbl[k].b, tbl[k].clr);
      check($sformatf("tbl%0d_y", k),    ys[0], tbl[k].ey);
      check($sformatf("tbl%0d_busy", k), bs[0], tbl[k].eb);
      check($sformatf("tbl%0d_cnt", k),  cs[0], tbl[k].ec);
    end

    phase = "nonoverlap";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_bits(32'b1011011, 7, 32'b0001000, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_bits(32'b10111011, 8, 32'b00010001, 1);

    phase = "six_bit";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_bits(32'b101101101, 9, 32'b000001001, 3);

    // Five overlapping matches on the 2-bit counter, then again clearing on the 5th.
    for (int run = 0; run < 2; run++) begin
      phase = run ? "sat_clear" : "sat";
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, (i % 3) != 1, (run == 1) && (i == 15));
        if (i >= 3 && (i % 3) == 0) begin
          check($sformatf("sat_y_m%0d", i / 3), ys[2], 1);
          check($sformatf("sat_cnt_m%0d", i / 3), cs[2],
                ((run == 1) && (i == 15)) ? 0 : ((i / 3 > 3) ? 3 : i / 3));
        end
      end
    end

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      logic v;
      v = ($urandom_range(3, 0) != 0);
      step($urandom_range(49, 0) == 0, v, 1'($urandom), v && ($urandom_range(29, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011, PAT_W bits wide: target sequence; PATTERN[PAT_W-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-005 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port x_in, input, 1 bit: serial data bit.
REQ-008 SHALL have port x_valid, input, 1 bit: x_in is sampled only when this is 1.
REQ-009 SHALL have port clear_cnt, input, 1 bit: synchronous clear of match_cnt.
REQ-010 SHALL have port y_out, output, 1 bit: registered one-cycle match pulse.
REQ-011 SHALL have port busy, output, 1 bit: registered; 1 when the partial-match depth is nonzero.
REQ-012 SHALL have port match_cnt, output, CNT_W bits: registered saturating count of matches.

Function
REQ-013 SHALL hold a state register `depth` in 0..PAT_W-1, equal to the number of leading PATTERN bits currently matched.
REQ-014 Transition rule: on a sampled bit b at depth d, if b equals PATTERN[PAT_W-1-d], the next depth is d+1; otherwise depth falls back along the KMP failure chain to the longest border k where the pattern prefix of length k followed by b is a prefix of PATTERN.
REQ-015 Failure and transition tables SHALL be computed at elaboration from PATTERN; no runtime table loading.
REQ-016 Match: a sampled bit that completes depth PAT_W SHALL set y_out=1 on the following cycle only; y_out SHALL be 0 in every other cycle.
REQ-017 After a match, depth SHALL become fail(PAT_W), the longest proper border of PATTERN, when OVERLAP=1, and 0 when OVERLAP=0.
REQ-018 When x_valid=0, depth, busy and match_cnt SHALL hold, and y_out SHALL be 0 next cycle.
REQ-019 busy SHALL equal (next depth != 0), registered alongside depth.
REQ-020 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-021 If clear_cnt=1 and a match occur in the same cycle, match_cnt SHALL become 0 and y_out SHALL still pulse.
REQ-022 Latency: 1 cycle from the sampled completing bit to y_out and the match_cnt update.

Reset
REQ-023 With reset=1 at a clock edge: depth=0, y_out=0, busy=0, match_cnt=0; reset SHALL override x_valid and clear_cnt.
REQ-024 Reset mid-sequence SHALL discard the partial match; detection restarts from depth 0 on the first valid bit after reset is released.

Structure
REQ-025 Package seq_det_pkg SHALL hold the default parameter constants and the elaboration-time failure-function and next-depth functions.
REQ-026 One sub-module, sat_counter (parameter CNT_W; inputs inc and clr; count output), SHALL implement match_cnt; the FSM SHALL stay in seq_detector.

Verification
REQ-027 PATTERN=1011, OVERLAP=1, valid bits 1,0,1,1,0,1,1 -> y_out pulses after bits 4 and 7; match_cnt=2.
REQ-028 Same stream with OVERLAP=0 -> one pulse after bit 4; stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8.
REQ-029 Bits 1,0 then x_valid=0 for 3 cycles then bits 1,1 -> single pulse after the last bit; busy=1 throughout the gap.
REQ-030 CNT_W=2, five matches -> match_cnt reads 1,2,3,3,3; clear_cnt asserted in the same cycle as the 5th match -> match_cnt=0 and y_out=1.
REQ-031 Bits 1,0,1, reset for 1 cycle, then 1 -> no pulse, busy=1 with depth=1; then 0,1,1 -> pulse.
REQ-032 PAT_W=6, PATTERN=101101, OVERLAP=1, stream 101101101 -> pulses after bits 6 and 9 (border=3).
